// File: rtl/csa_adder_32.sv
// 32-bit carry-select adder: ripple-carry blocks of BLK_W bits, each upper block
// precomputing both carry-in cases, plus a registered copy of the result.

module csa_rca #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_c,
    output logic [W-1:0] o_s,
    output logic         o_c
);
    logic [W:0] w_c;

    assign w_c[0] = i_c;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
        assign w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_c = w_c[W];
endmodule

module csa_adder_32 #(
    parameter int BLK_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout,
    output logic        ov,
    output logic [31:0] sum_q,
    output logic        cout_q,
    output logic        ov_q
);
    localparam int NBLK = 32 / BLK_W;

    // w_blk_c[k] is the resolved carry into block k
    logic [NBLK:0] w_blk_c;
    logic [31:0]   r_sum;
    logic          r_cout;
    logic          r_ov;

    assign w_blk_c[0] = cin;

    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        if (k == 0) begin : g_first
            csa_rca #(.W(BLK_W)) u_rca (
                .i_a (a[0 +: BLK_W]),
                .i_b (b[0 +: BLK_W]),
                .i_c (w_blk_c[0]),
                .o_s (sum[0 +: BLK_W]),
                .o_c (w_blk_c[1])
            );
        end else begin : g_sel
            logic [BLK_W-1:0] w_s0;
            logic [BLK_W-1:0] w_s1;
            logic             w_c0;
            logic             w_c1;

            csa_rca #(.W(BLK_W)) u_rca0 (
                .i_a (a[k*BLK_W +: BLK_W]),
                .i_b (b[k*BLK_W +: BLK_W]),
                .i_c (1'b0),
                .o_s (w_s0),
                .o_c (w_c0)
            );
            csa_rca #(.W(BLK_W)) u_rca1 (
                .i_a (a[k*BLK_W +: BLK_W]),
                .i_b (b[k*BLK_W +: BLK_W]),
                .i_c (1'b1),
                .o_s (w_s1),
                .o_c (w_c1)
            );

            assign sum[k*BLK_W +: BLK_W] = w_blk_c[k] ? w_s1 : w_s0;
            assign w_blk_c[k+1]          = w_blk_c[k] ? w_c1 : w_c0;
        end
    end

    assign cout = w_blk_c[NBLK];
    // Same-sign operands producing an opposite-sign result: equals c_in(31) ^ c_out(31)
    assign ov   = (a[31] ~^ b[31]) & (sum[31] ^ a[31]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ov   <= 1'b0;
        end else begin
            r_sum  <= sum;
            r_cout <= cout;
            r_ov   <= ov;
        end
    end

    assign sum_q  = r_sum;
    assign cout_q = r_cout;
    assign ov_q   = r_ov;
endmodule

// File: tb/tb_csa_adder_32.sv
// Scoreboarded bench for csa_adder_32: combinational outputs checked as driven,
// registered outputs checked by a monitor popping the expected queue each edge.

module tb_csa_adder_32;
    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic        ov;
    logic [31:0] sum_q;
    logic        cout_q;
    logic        ov_q;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   n_chk  = 0;
    int   n_fail = 0;

    csa_adder_32 #(.BLK_W(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .sum    (sum),
        .cout   (cout),
        .ov     (ov),
        .sum_q  (sum_q),
        .cout_q (cout_q),
        .ov_q   (ov_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: 33-bit unsigned sum and an exact signed sum in 64 bits
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic c);
        exp_t        e;
        logic [32:0] u;
        longint      sv;
        u   = {1'b0, x} + {1'b0, y} + {32'b0, c};
        sv  = longint'($signed(x)) + longint'($signed(y)) + longint'({31'b0, c});
        e.s = u[31:0];
        e.c = u[32];
        e.o = (sv != longint'($signed(u[31:0])));
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic [31:0] ta, input logic [31:0] bb, input logic tc);
        exp_t e;
        @(negedge clk);
        a   = ta;
        b   = bb;
        cin = tc;
        #1;
        e = model(ta, bb, tc);
        chk("sum", sum, e.s);
        chk("cout", {31'b0, cout}, {31'b0, e.c});
        chk("ov", {31'b0, ov}, {31'b0, e.o});
        if (rst_n) q.push_back(e);
    endtask

    task automatic directed(input logic [31:0] ta, input logic [31:0] bb, input logic tc,
                            input logic [31:0] es, input logic ec, input logic eo);
        apply(ta, bb, tc);
        chk("dir_sum", sum, es);
        chk("dir_cout", {31'b0, cout}, {31'b0, ec});
        chk("dir_ov", {31'b0, ov}, {31'b0, eo});
    endtask

    // Registered outputs must match the value presented one edge earlier
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            me = q.pop_front();
            chk("sum_q", sum_q, me.s);
            chk("cout_q", {31'b0, cout_q}, {31'b0, me.c});
            chk("ov_q", {31'b0, ov_q}, {31'b0, me.o});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t held;
        rst_n = 1'b0;
        a     = 32'h1234_5678;
        b     = 32'h0000_0001;
        cin   = 1'b0;
        #2;
        chk("rst_sum_q", sum_q, 32'h0);
        chk("rst_cout_q", {31'b0, cout_q}, 32'h0);
        chk("rst_ov_q", {31'b0, ov_q}, 32'h0);
        chk("rst_comb_sum", sum, 32'h1234_5679);
        @(negedge clk);
        rst_n = 1'b1;

        directed(32'h0000_0000, 32'h0000_0001, 1'b0, 32'h0000_0001, 1'b0, 1'b0);
        directed(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        directed(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        directed(32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0001, 1'b1, 1'b1);
        directed(32'h0000_000F, 32'h0000_0003, 1'b1, 32'h0000_0013, 1'b0, 1'b0);
        directed(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        directed(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Mid-operation reset: registered copy cleared at once, comb path untouched
        apply(32'hDEAD_BEEF, 32'h1111_1111, 1'b1);
        held = model(32'hDEAD_BEEF, 32'h1111_1111, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sum_q", sum_q, 32'h0);
        chk("mid_rst_cout_q", {31'b0, cout_q}, 32'h0);
        chk("mid_rst_ov_q", {31'b0, ov_q}, 32'h0);
        chk("mid_rst_sum", sum, held.s);
        @(posedge clk);
        #2;
        chk("rst_hold_sum_q", sum_q, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10000; i++)
            apply($urandom, $urandom, 1'($urandom_range(0, 1)));

        for (int i = 0; i < 3 && q.size() > 0; i++) @(posedge clk);
        #2;
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
